arithmetic_unit: RTL and testbench

RV32I-style integer ALU for register-register operations (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND), selected by the instruction funct3 field (`operation`, bits 14:12) and funct7 field (`metadata`, bits 31:25).
- Sits in the execute stage, fed by the register-read and decode stages.
- Each input carries a valid qualifier.
- The primary result path is combinational (zero latency).
- A registered copy of the result is also provided for pipelined consumers.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/arith_shifter.sv | 35 +++
 rtl/arithmetic_unit.sv | 75 +++++++
 tb/tb_arithmetic_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared funct3/funct7 encodings and datapath width for the ALU
package arith_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SR      = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } funct3_e;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/arith_shifter.sv
// rtl/arith_shifter.sv - barrel shifter for SLL/SRL/SRA using the full rhs as amount
module arith_shifter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [XLEN-1:0] amount,
    input  logic            shift_right,
    input  logic            arith,
    output logic [XLEN-1:0] shifted
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] LIMIT = XLEN'(XLEN);

    logic [SW-1:0] shamt;
    logic          saturate;
    logic          fill;

    always_comb begin
        shamt    = amount[SW-1:0];
        saturate = (amount >= LIMIT);
        // Only an arithmetic right shift replicates the sign once everything is shifted out
        fill     = shift_right & arith & data[XLEN-1];
        if (saturate) begin
            shifted = {XLEN{fill}};
        end else if (!shift_right) begin
            shifted = data << shamt;
        end else if (arith) begin
            shifted = $unsigned($signed(data) >>> shamt);
        end else begin
            shifted = data >> shamt;
        end
    end

endmodule

// File: rtl/arithmetic_unit.sv
// rtl/arithmetic_unit.sv - RV32I register-register ALU with combinational and registered result
module arithmetic_unit #(
    parameter int XLEN = arith_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lhs,
    input  logic            lhs_valid,
    input  logic [XLEN-1:0] rhs,
    input  logic            rhs_valid,
    input  logic [2:0]      operation,
    input  logic            operation_valid,
    input  logic [6:0]      metadata,
    input  logic            metadata_valid,
    output logic [XLEN-1:0] result,
    output logic            arithmetic_code_legal,
    output logic            result_valid,
    output logic [XLEN-1:0] result_q,
    output logic            result_valid_q
);

    import arith_pkg::*;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] result_d;
    logic            result_valid_d;
    logic            alt;

    assign alt = (metadata == F7_ALT);

    arith_shifter #(.XLEN(XLEN)) u_shifter (
        .data        (lhs),
        .amount      (rhs),
        .shift_right (operation == SR),
        .arith       (alt),
        .shifted     (shifted)
    );

    always_comb begin
        arithmetic_code_legal = (metadata == F7_BASE)
                              || (alt && (operation == ADD_SUB || operation == SR));
        alu_out = '0;
        case (funct3_e'(operation))
            ADD_SUB: alu_out = alt ? (lhs - rhs) : (lhs + rhs);
            SLL:     alu_out = shifted;
            SLT:     alu_out = {{(XLEN-1){1'b0}}, ($signed(lhs) < $signed(rhs))};
            SLTU:    alu_out = {{(XLEN-1){1'b0}}, (lhs < rhs)};
            XOR:     alu_out = lhs ^ rhs;
            SR:      alu_out = shifted;
            OR:      alu_out = lhs | rhs;
            AND:     alu_out = lhs & rhs;
            default: alu_out = '0;
        endcase
        result_valid = lhs_valid & rhs_valid & operation_valid & metadata_valid
                     & arithmetic_code_legal;
        result       = result_valid ? alu_out : '0;
    end

    always_comb begin
        result_d       = result;
        result_valid_d = result_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

endmodule

// File: tb/tb_arithmetic_unit.sv
// tb/tb_arithmetic_unit.sv - directed table plus randomized model checks for arithmetic_unit
module tb_arithmetic_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] lhs = '0;
    logic        lhs_valid = 1'b0;
    logic [31:0] rhs = '0;
    logic        rhs_valid = 1'b0;
    logic [2:0]  operation = '0;
    logic        operation_valid = 1'b0;
    logic [6:0]  metadata = '0;
    logic        metadata_valid = 1'b0;
    logic [31:0] result;
    logic        arithmetic_code_legal;
    logic        result_valid;
    logic [31:0] result_q;
    logic        result_valid_q;

    int checks = 0;
    int errors = 0;

    arithmetic_unit #(.XLEN(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .lhs                   (lhs),
        .lhs_valid             (lhs_valid),
        .rhs                   (rhs),
        .rhs_valid             (rhs_valid),
        .operation             (operation),
        .operation_valid       (operation_valid),
        .metadata              (metadata),
        .metadata_valid        (metadata_valid),
        .result                (result),
        .arithmetic_code_legal (arithmetic_code_legal),
        .result_valid          (result_valid),
        .result_q              (result_q),
        .result_valid_q        (result_valid_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [6:0]  meta;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  vld;
        logic        legal;
        logic        valid;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic        legal;
        logic        valid;
        logic [31:0] res;
    } exp_t;

    vec_t vecs[$];

    function automatic void add_vec(logic [2:0] op, logic [6:0] meta, logic [31:0] a,
                                    logic [31:0] b, logic [3:0] vld, logic legal,
                                    logic valid, logic [31:0] res);
        vec_t v;
        v.op = op; v.meta = meta; v.a = a; v.b = b; v.vld = vld;
        v.legal = legal; v.valid = valid; v.res = res;
        vecs.push_back(v);
    endfunction

    // Reference model: RV32I semantics expressed with plain integer arithmetic
    function automatic exp_t model(logic [2:0] op, logic [6:0] meta, logic [31:0] a,
                                   logic [31:0] b, logic [3:0] vld);
        exp_t e;
        longint unsigned p;
        longint s;
        logic [31:0] r;
        e.legal = (meta == 7'h00) || (meta == 7'h20 && (op == 3'd0 || op == 3'd5));
        e.valid = (vld == 4'hF) && e.legal;
        p = (b < 32) ? (64'd1 << b) : 64'd0;
        r = '0;
        case (op)
            3'd0: r = (meta == 7'h20) ? a - b : a + b;
            3'd1: r = (b >= 32) ? 32'd0 : 32'((longint'(a) * p) % 64'h1_0000_0000);
            3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (meta == 7'h20) begin
                    s = longint'(int'(a));
                    if (b >= 32)     r = (s < 0) ? 32'hFFFF_FFFF : 32'd0;
                    else if (s >= 0) r = 32'(s / longint'(p));
                    else             r = 32'(-((-s + longint'(p) - 1) / longint'(p)));
                end else begin
                    r = (b >= 32) ? 32'd0 : 32'(longint'(a) / longint'(p));
                end
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        e.res = e.valid ? r : 32'd0;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic [2:0] op, logic [6:0] meta, logic [31:0] a, logic [31:0] b,
                         logic [3:0] vld);
        operation = op; metadata = meta; lhs = a; rhs = b;
        {lhs_valid, rhs_valid, operation_valid, metadata_valid} = vld;
    endtask

    exp_t prev;
    exp_t cur;

    initial begin
        add_vec(3'd0, 7'h00, 32'h1,         32'hFFFF,      4'hF, 1, 1, 32'h0001_0000);
        add_vec(3'd0, 7'h00, 32'h1,         32'hFFFF_FFFF, 4'hF, 1, 1, 32'h0);
        add_vec(3'd0, 7'h20, 32'h0,         32'h1,         4'hF, 1, 1, 32'hFFFF_FFFF);
        add_vec(3'd0, 7'h20, 32'h0001_0000, 32'h1,         4'hF, 1, 1, 32'h0000_FFFF);
        add_vec(3'd0, 7'h01, 32'h5,         32'h6,         4'hF, 0, 0, 32'h0);
        add_vec(3'd0, 7'h00, 32'h5,         32'h6,         4'h7, 1, 0, 32'h0);
        add_vec(3'd0, 7'h00, 32'h5,         32'h6,         4'hB, 1, 0, 32'h0);
        add_vec(3'd0, 7'h00, 32'h5,         32'h6,         4'hD, 1, 0, 32'h0);
        add_vec(3'd0, 7'h00, 32'h5,         32'h6,         4'hE, 1, 0, 32'h0);
        add_vec(3'd4, 7'h00, 32'h1111_FFFF, 32'h0204_F0F0, 4'hF, 1, 1, 32'h1315_0F0F);
        add_vec(3'd6, 7'h00, 32'h1020_F171, 32'hE0D1_F886, 4'hF, 1, 1, 32'hF0F1_F9F7);
        add_vec(3'd7, 7'h00, 32'h0FF8_12A6, 32'hFF17_2583, 4'hF, 1, 1, 32'h0F10_0082);
        add_vec(3'd1, 7'h00, 32'hF2F8_3107, 32'd1,         4'hF, 1, 1, 32'hE5F0_620E);
        add_vec(3'd1, 7'h00, 32'hF2F8_3107, 32'd0,         4'hF, 1, 1, 32'hF2F8_3107);
        add_vec(3'd1, 7'h00, 32'hF2F8_3107, 32'd4,         4'hF, 1, 1, 32'h2F83_1070);
        add_vec(3'd1, 7'h00, 32'hF2F8_3107, 32'd32,        4'hF, 1, 1, 32'h0);
        add_vec(3'd5, 7'h00, 32'h4863_201F, 32'd1,         4'hF, 1, 1, 32'h2431_900F);
        add_vec(3'd5, 7'h00, 32'h4863_201F, 32'd4,         4'hF, 1, 1, 32'h0486_3201);
        add_vec(3'd5, 7'h00, 32'h4863_201F, 32'd32,        4'hF, 1, 1, 32'h0);
        add_vec(3'd5, 7'h20, 32'hA863_201F, 32'd1,         4'hF, 1, 1, 32'hD431_900F);
        add_vec(3'd5, 7'h20, 32'hA863_201F, 32'd4,         4'hF, 1, 1, 32'hFA86_3201);
        add_vec(3'd5, 7'h20, 32'hA863_201F, 32'd32,        4'hF, 1, 1, 32'hFFFF_FFFF);
        add_vec(3'd5, 7'h20, 32'hA863_201F, 32'h8000_0000, 4'hF, 1, 1, 32'hFFFF_FFFF);
        add_vec(3'd2, 7'h00, 32'h0,         32'hFFFF_FFFF, 4'hF, 1, 1, 32'h0);
        add_vec(3'd2, 7'h00, 32'hFFFF_FFFF, 32'h0,         4'hF, 1, 1, 32'h1);
        add_vec(3'd3, 7'h00, 32'h0,         32'hFFFF_FFFF, 4'hF, 1, 1, 32'h1);
        add_vec(3'd3, 7'h00, 32'hFFFF_FFFF, 32'h0,         4'hF, 1, 1, 32'h0);
        add_vec(3'd2, 7'h00, 32'h1234_5678, 32'h1234_5678, 4'hF, 1, 1, 32'h0);
        add_vec(3'd3, 7'h00, 32'h1234_5678, 32'h1234_5678, 4'hF, 1, 1, 32'h0);
        add_vec(3'd1, 7'h20, 32'h1,         32'h1,         4'hF, 0, 0, 32'h0);
        add_vec(3'd7, 7'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0);

        // Combinational path works while held in reset; flops stay cleared
        drive(3'd0, 7'h00, 32'h2, 32'h3, 4'hF);
        #1;
        chk("reset_result_q", result_q, 32'h0);
        chk("reset_valid_q", {31'b0, result_valid_q}, 32'h0);
        chk("reset_comb_result", result, 32'h5);
        @(posedge clk); #1;
        chk("reset_hold_q", result_q, 32'h0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk); #2;
            drive(vecs[i].op, vecs[i].meta, vecs[i].a, vecs[i].b, vecs[i].vld);
            #1;
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_legal", i), {31'b0, arithmetic_code_legal},
                {31'b0, vecs[i].legal});
            chk($sformatf("vec%0d_valid", i), {31'b0, result_valid}, {31'b0, vecs[i].valid});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_result_q", i), result_q, vecs[i].res);
            chk($sformatf("vec%0d_valid_q", i), {31'b0, result_valid_q}, {31'b0, vecs[i].valid});
        end

        // Randomized: registered outputs must show the previous cycle's expectation
        prev = model(3'd7, 7'h20, 32'h0, 32'h0, 4'h0);
        drive(3'd7, 7'h20, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  op;
            logic [6:0]  meta;
            logic [31:0] a;
            logic [31:0] b;
            logic [3:0]  vld;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    meta = 7'h00;
                2:       meta = 7'h20;
                default: meta = 7'($urandom);
            endcase
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            vld = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            cur = model(op, meta, a, b, vld);
            #2;
            drive(op, meta, a, b, vld);
            #1;
            chk($sformatf("rnd%0d_result", n), result, cur.res);
            chk($sformatf("rnd%0d_legal", n), {31'b0, arithmetic_code_legal}, {31'b0, cur.legal});
            chk($sformatf("rnd%0d_valid", n), {31'b0, result_valid}, {31'b0, cur.valid});
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_result_q", n), result_q, cur.res);
            chk($sformatf("rnd%0d_valid_q", n), {31'b0, result_valid_q}, {31'b0, cur.valid});
            prev = cur;
            @(negedge clk);
            chk($sformatf("rnd%0d_hold_q", n), result_q, prev.res);
            @(posedge clk);
        end

        // Asynchronous reset mid-run, then capture on the first edge after release
        drive(3'd0, 7'h00, 32'h1, 32'hFFFF, 4'hF);
        @(posedge clk); #1;
        chk("pre_rst_q", result_q, 32'h0001_0000);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_result_q", result_q, 32'h0);
        chk("async_rst_valid_q", {31'b0, result_valid_q}, 32'h0);
        chk("async_rst_comb", result, 32'h0001_0000);
        @(posedge clk); #1;
        chk("rst_held_q", result_q, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("release_no_edge_q", result_q, 32'h0);
        @(posedge clk); #1;
        chk("release_capture_q", result_q, 32'h0001_0000);
        chk("release_capture_valid_q", {31'b0, result_valid_q}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
